// File: rtl/lebug_pkg.sv
// Shared types and constants for the trace packing path.
package lebug_pkg;

    // Default geometry of the trace path.
    localparam int LEBUG_N              = 8;
    localparam int LEBUG_DATA_WIDTH     = 32;
    localparam int LEBUG_DROP_CNT_WIDTH = 16;

    // Lane index for the default lane count. Modules with other N derive
    // their own index type from the same expression.
    localparam int LANE_IDX_W = (LEBUG_N > 1) ? $clog2(LEBUG_N) : 1;
    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // Saturation value of the default-width drop counter.
    localparam logic [LEBUG_DROP_CNT_WIDTH-1:0] DROP_SAT = {LEBUG_DROP_CNT_WIDTH{1'b1}};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
    import lebug_pkg::*;
#(
    parameter int WIDTH = LEBUG_DROP_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] SAT = {WIDTH{1'b1}};

    // Count up on inc, hold at all-ones, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != SAT)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/trace_vector_packer.sv
// Packs single trace elements into N-lane vectors and issues one enqueue
// per completed vector; vectors hitting a full buffer are dropped and counted.
module trace_vector_packer
    import lebug_pkg::*;
#(
    parameter int N              = LEBUG_N,
    parameter int DATA_WIDTH     = LEBUG_DATA_WIDTH,
    parameter int DROP_CNT_WIDTH = LEBUG_DROP_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tracing,
    input  logic                      valid_in,
    input  logic                      eof_in,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      buf_full,
    output logic                      enqueue,
    output logic                      eof_out,
    output logic [DATA_WIDTH-1:0]     vector_out [N],
    output logic [DROP_CNT_WIDTH-1:0] dropped_count,
    input  logic                      clear_drops
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;
    typedef logic [LW-1:0] lane_t;
    localparam lane_t LAST_LANE = lane_t'(N - 1);

    lane_t                  idx;
    logic [DATA_WIDTH-1:0]  acc [N];
    logic                   accept;
    logic                   close;
    logic                   drop;

    assign accept = valid_in & tracing;
    // Close on the last lane or on a frame end, whichever comes first, so an
    // eof on lane N-1 yields a single vector.
    assign close  = accept & ((idx == LAST_LANE) | eof_in);
    assign drop   = close & buf_full;

    // Accumulate lanes, hand the finished vector to the output register and
    // discard any partial vector when tracing drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            enqueue <= 1'b0;
            eof_out <= 1'b0;
            for (int k = 0; k < N; k++) begin
                acc[k]        <= '0;
                vector_out[k] <= '0;
            end
        end else begin
            enqueue <= close & ~buf_full;
            if (close) begin
                // Closing element goes straight to the output; untouched lanes
                // are still zero from the previous clear.
                for (int k = 0; k < N; k++) begin
                    vector_out[k] <= (lane_t'(k) == idx) ? data_in : acc[k];
                    acc[k]        <= '0;
                end
                eof_out <= eof_in;
                idx     <= '0;
            end else if (accept) begin
                acc[idx] <= data_in;
                idx      <= idx + lane_t'(1);
            end else if (!tracing && (idx != '0)) begin
                for (int k = 0; k < N; k++) begin
                    acc[k] <= '0;
                end
                idx <= '0;
            end
        end
    end

    sat_counter #(
        .WIDTH (DROP_CNT_WIDTH)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop),
        .clr   (clear_drops),
        .count (dropped_count)
    );

endmodule

// File: tb/tb_trace_vector_packer.sv
// Directed bench for trace_vector_packer with hand-computed expectations.
module tb_trace_vector_packer;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tracing = 1'b0;
    logic          valid_in = 1'b0;
    logic          eof_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          buf_full = 1'b0;
    logic          enqueue;
    logic          eof_out;
    logic [DW-1:0] vector_out [N];
    logic [CW-1:0] dropped_count;
    logic          clear_drops = 1'b0;

    int tests = 0;
    int fails = 0;

    trace_vector_packer #(.N(N), .DATA_WIDTH(DW), .DROP_CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tracing       (tracing),
        .valid_in      (valid_in),
        .eof_in        (eof_in),
        .data_in       (data_in),
        .buf_full      (buf_full),
        .enqueue       (enqueue),
        .eof_out       (eof_out),
        .vector_out    (vector_out),
        .dropped_count (dropped_count),
        .clear_drops   (clear_drops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one input cycle, then sample just after the edge.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic e);
        valid_in = v;
        data_in  = d;
        eof_in   = e;
        tick();
    endtask

    task automatic chk_lanes(input string tag, input logic [DW-1:0] exp [N]);
        for (int k = 0; k < N; k++)
            chk($sformatf("%s_lane%0d", tag, k), 64'(vector_out[k]), 64'(exp[k]));
    endtask

    logic [DW-1:0] exp_v [N];

    initial begin
        // Reset state
        #2;
        chk("rst_enqueue", 64'(enqueue), 64'd0);
        chk("rst_eof", 64'(eof_out), 64'd0);
        chk("rst_drops", 64'(dropped_count), 64'd0);
        chk("rst_lane0", 64'(vector_out[0]), 64'd0);
        tick();
        rst_n   = 1'b1;
        tracing = 1'b1;
        tick();

        // 8 elements, eof on the 8th
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), i == 8);
            if (i < 8) chk($sformatf("t1_noenq%0d", i), 64'(enqueue), 64'd0);
        end
        chk("t1_enq", 64'(enqueue), 64'd1);
        chk("t1_eof", 64'(eof_out), 64'd1);
        chk("t1_drops", 64'(dropped_count), 64'd0);
        for (int k = 0; k < N; k++) exp_v[k] = DW'(k + 1);
        chk_lanes("t1", exp_v);
        drive(1'b0, '0, 1'b0);
        chk("t1_single", 64'(enqueue), 64'd0);

        // 11 elements, eof on the 11th: full vector then short vector
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, DW'(32'h10 + i), i == 10);
            if (i == 7) begin
                chk("t2_enq1", 64'(enqueue), 64'd1);
                chk("t2_eof1", 64'(eof_out), 64'd0);
                for (int k = 0; k < N; k++) exp_v[k] = DW'(32'h10 + k);
                chk_lanes("t2a", exp_v);
            end else if (i == 10) begin
                chk("t2_enq2", 64'(enqueue), 64'd1);
                chk("t2_eof2", 64'(eof_out), 64'd1);
                for (int k = 0; k < N; k++) exp_v[k] = '0;
                exp_v[0] = 32'h18; exp_v[1] = 32'h19; exp_v[2] = 32'h1A;
                chk_lanes("t2b", exp_v);
            end else begin
                chk($sformatf("t2_noenq%0d", i), 64'(enqueue), 64'd0);
            end
        end

        // Every other cycle, 16 elements; eof on idle cycles must be ignored
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, DW'(32'h40 + i), 1'b0);
            chk($sformatf("t3_enq%0d", i), 64'(enqueue), (i == 7 || i == 15) ? 64'd1 : 64'd0);
            if (i == 7 || i == 15) begin
                for (int k = 0; k < N; k++) exp_v[k] = DW'(32'h40 + (i - 7) + k);
                chk_lanes($sformatf("t3_%0d", i), exp_v);
                chk($sformatf("t3_eof%0d", i), 64'(eof_out), 64'd0);
            end
            drive(1'b0, 32'hDEAD, 1'b1);
            chk($sformatf("t3_idle%0d", i), 64'(enqueue), 64'd0);
        end

        // Partial vector discarded by tracing low
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hAA + DW'(i), 1'b0);
        tracing = 1'b0;
        drive(1'b1, 32'hBAD0, 1'b1);
        chk("t4_off1", 64'(enqueue), 64'd0);
        drive(1'b1, 32'hBAD1, 1'b0);
        chk("t4_off2", 64'(enqueue), 64'd0);
        tracing = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(32'h20 + i), 1'b0);
            chk($sformatf("t4_enq%0d", i), 64'(enqueue), (i == 7) ? 64'd1 : 64'd0);
        end
        for (int k = 0; k < N; k++) exp_v[k] = DW'(32'h20 + k);
        chk_lanes("t4", exp_v);
        chk("t4_drops", 64'(dropped_count), 64'd0);

        // Three dropped closes, then clear coincident with a fourth drop
        buf_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(32'h50 + i), 1'b1);
            chk($sformatf("t5_noenq%0d", i), 64'(enqueue), 64'd0);
        end
        chk("t5_drops3", 64'(dropped_count), 64'd3);
        clear_drops = 1'b1;
        drive(1'b1, 32'h53, 1'b1);
        clear_drops = 1'b0;
        chk("t5_clear_wins", 64'(dropped_count), 64'd0);
        chk("t5_noenq_clr", 64'(enqueue), 64'd0);
        drive(1'b1, 32'h54, 1'b1);
        chk("t5_drops1", 64'(dropped_count), 64'd1);
        buf_full = 1'b0;
        drive(1'b1, 32'h77, 1'b1);
        chk("t5_enq_after", 64'(enqueue), 64'd1);
        chk("t5_lane0", 64'(vector_out[0]), 64'h77);
        chk("t5_lane1", 64'(vector_out[1]), 64'd0);

        // Asynchronous reset mid-vector
        for (int i = 0; i < 5; i++) drive(1'b1, DW'(32'h60 + i), 1'b0);
        valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_enq", 64'(enqueue), 64'd0);
        chk("t6_rst_eof", 64'(eof_out), 64'd0);
        chk("t6_rst_lane0", 64'(vector_out[0]), 64'd0);
        chk("t6_rst_drops", 64'(dropped_count), 64'd0);
        #2 rst_n = 1'b1;
        drive(1'b0, '0, 1'b0);
        chk("t6_noenq_rel", 64'(enqueue), 64'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(32'h30 + i), 1'b0);
            chk($sformatf("t6_enq%0d", i), 64'(enqueue), (i == 7) ? 64'd1 : 64'd0);
        end
        for (int k = 0; k < N; k++) exp_v[k] = DW'(32'h30 + k);
        chk_lanes("t6", exp_v);
        chk("t6_eof", 64'(eof_out), 64'd0);
        drive(1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
